// File: rtl/clk_meas_pkg.sv
// Shared types and constants for the clock period meter.
package clk_meas_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE
  } meas_state_t;

  // Two consecutive periods this close (in clk_in cycles) count as stable.
  localparam int LOCK_TOL = 1;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser for an asynchronous input plus a delay flop for
// single-cycle rising-edge detection in the clk_in domain.
module sync_edge_det (
  input  logic clk_in,
  input  logic reset,
  input  logic d_async,
  output logic d_sync,
  output logic rise
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d_async;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign d_sync = s2_q;
  assign rise   = s2_q & ~s3_q;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow asynchronous input in clk_in
// cycles, with lock detection and a sticky timeout for a missing input.
module clk_period_meter
  import clk_meas_pkg::*;
#(
  parameter int MAX_PERIOD = 1_000_000,
  parameter int CNT_WIDTH  = $clog2(MAX_PERIOD + 1)
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 sig_in,
  output logic [CNT_WIDTH-1:0] period,
  output logic [CNT_WIDTH-1:0] high_time,
  output logic                 meas_valid,
  output logic                 timeout,
  output logic                 locked
);

  localparam logic [CNT_WIDTH-1:0] CntMax = CNT_WIDTH'(MAX_PERIOD);
  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH:0]   LockTol = (CNT_WIDTH + 1)'(LOCK_TOL);

  logic sigSync;
  logic sigRise;

  meas_state_t           state_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [CNT_WIDTH-1:0]  hcnt_q;
  logic [CNT_WIDTH-1:0]  period_q;
  logic [CNT_WIDTH-1:0]  highTime_q;
  logic                  measValid_q;
  logic                  timeout_q;
  logic                  locked_q;
  logic                  firstResult_q;

  logic [CNT_WIDTH:0]    periodDiff_d;
  logic                  withinTol_d;

  sync_edge_det u_sync (
    .clk_in  (clk_in),
    .reset   (reset),
    .d_async (sig_in),
    .d_sync  (sigSync),
    .rise    (sigRise)
  );

  // Absolute difference between the period just closed and the previous result.
  always_comb begin
    periodDiff_d = '0;
    if (cnt_q >= period_q) begin
      periodDiff_d = {1'b0, cnt_q} - {1'b0, period_q};
    end else begin
      periodDiff_d = {1'b0, period_q} - {1'b0, cnt_q};
    end
    withinTol_d = (periodDiff_d <= LockTol);
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      hcnt_q        <= '0;
      period_q      <= '0;
      highTime_q    <= '0;
      measValid_q   <= 1'b0;
      timeout_q     <= 1'b0;
      locked_q      <= 1'b0;
      firstResult_q <= 1'b0;
    end else begin
      measValid_q <= 1'b0;
      if (!en) begin
        state_q       <= IDLE;
        cnt_q         <= '0;
        hcnt_q        <= '0;
        timeout_q     <= 1'b0;
        locked_q      <= 1'b0;
        firstResult_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= ARM;
            cnt_q   <= '0;
            hcnt_q  <= '0;
          end
          // The first rise only starts the count; the period before it is unknown.
          ARM: begin
            if (sigRise) begin
              cnt_q         <= CntOne;
              hcnt_q        <= CntOne;
              firstResult_q <= 1'b1;
              state_q       <= MEASURE;
            end
          end
          MEASURE: begin
            if (sigRise) begin
              period_q      <= cnt_q;
              highTime_q    <= hcnt_q;
              measValid_q   <= 1'b1;
              timeout_q     <= 1'b0;
              locked_q      <= ~firstResult_q & withinTol_d;
              firstResult_q <= 1'b0;
              cnt_q         <= CntOne;
              hcnt_q        <= CntOne;
            end else if (cnt_q == CntMax) begin
              timeout_q <= 1'b1;
              locked_q  <= 1'b0;
              cnt_q     <= '0;
              hcnt_q    <= '0;
              state_q   <= ARM;
            end else begin
              cnt_q  <= cnt_q + CntOne;
              hcnt_q <= hcnt_q + CNT_WIDTH'(sigSync);
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hcnt_q  <= '0;
          end
        endcase
      end
    end
  end

  assign period     = period_q;
  assign high_time  = highTime_q;
  assign meas_valid = measValid_q;
  assign timeout    = timeout_q;
  assign locked     = locked_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Scoreboard bench for clk_period_meter: directed pulse trains with expected
// results queued at each rise and checked whenever meas_valid fires.
module tb_clk_period_meter;

  localparam int MaxPeriod = 1000;
  localparam int CntWidth  = $clog2(MaxPeriod + 1);

  logic                clk_in = 1'b0;
  logic                reset;
  logic                en;
  logic                sig_in;
  logic [CntWidth-1:0] period;
  logic [CntWidth-1:0] high_time;
  logic                meas_valid;
  logic                timeout;
  logic                locked;

  typedef struct packed {
    logic [CntWidth-1:0] period;
    logic [CntWidth-1:0] highTime;
    logic                locked;
  } expResult_t;

  expResult_t expQueue[$];
  expResult_t monItem;

  int checks   = 0;
  int failures = 0;

  bit measuring = 1'b0;
  bit hasResult = 1'b0;
  int lastP = 0;
  int lastH = 0;
  int pendP = 0;
  int pendH = 0;

  clk_period_meter #(
    .MAX_PERIOD (MaxPeriod),
    .CNT_WIDTH  (CntWidth)
  ) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .en         (en),
    .sig_in     (sig_in),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .timeout    (timeout),
    .locked     (locked)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // A new rise closes the pulse started before it, so its result is queued here.
  task automatic modelStart(input int p, input int h);
    expResult_t item;
    int diff;
    if (measuring) begin
      diff = pendP - lastP;
      if (diff < 0) diff = -diff;
      item.period   = CntWidth'(pendP);
      item.highTime = CntWidth'(pendH);
      item.locked   = hasResult && (diff <= 1);
      expQueue.push_back(item);
      lastP     = pendP;
      lastH     = pendH;
      hasResult = 1'b1;
    end else begin
      measuring = 1'b1;
      hasResult = 1'b0;
    end
    pendP = p;
    pendH = h;
  endtask

  task automatic applyStimulus(input int p, input int h);
    modelStart(p, h);
    sig_in = 1'b1;
    repeat (h) @(negedge clk_in);
    sig_in = 1'b0;
    repeat (p - h) @(negedge clk_in);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_period"}, int'(period), 0);
    checkOutput({tag, "_high_time"}, int'(high_time), 0);
    checkOutput({tag, "_meas_valid"}, int'(meas_valid), 0);
    checkOutput({tag, "_timeout"}, int'(timeout), 0);
    checkOutput({tag, "_locked"}, int'(locked), 0);
  endtask

  always @(negedge clk_in) begin
    if (!reset && meas_valid) begin
      if (expQueue.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_valid: got meas_valid=1 period=%0d, expected no result", period);
      end else begin
        monItem = expQueue.pop_front();
        checkOutput("sb_period", int'(period), int'(monItem.period));
        checkOutput("sb_high_time", int'(high_time), int'(monItem.highTime));
        checkOutput("sb_locked", int'(locked), int'(monItem.locked));
        checkOutput("sb_timeout", int'(timeout), 0);
      end
    end
  end

  initial begin
    #1_000_000;
    failures++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset  = 1'b1;
    en     = 1'b0;
    sig_in = 1'b0;
    repeat (3) @(negedge clk_in);
    checkAllZero("reset");
    reset = 1'b0;
    @(negedge clk_in);
    en = 1'b1;
    repeat (3) @(negedge clk_in);

    $display("[TB] 50%% duty, period 100");
    repeat (4) applyStimulus(100, 50);

    $display("[TB] alternating 101/100 then step to 150");
    for (int i = 0; i < 4; i++) applyStimulus((i % 2 == 0) ? 101 : 100, 50);
    repeat (2) applyStimulus(150, 75);

    $display("[TB] short periods 4/1 and 2/1");
    repeat (3) applyStimulus(4, 1);
    repeat (3) applyStimulus(2, 1);
    repeat (2) applyStimulus(100, 50);

    $display("[TB] timeout after last rise");
    modelStart(100, 50);
    sig_in = 1'b1;
    for (int n = 1; n <= 1003; n++) begin
      @(negedge clk_in);
      if (n == 50) sig_in = 1'b0;
      if (n == 1002) checkOutput("timeout_not_yet", int'(timeout), 0);
      if (n == 1003) begin
        checkOutput("timeout_set", int'(timeout), 1);
        checkOutput("timeout_locked", int'(locked), 0);
        checkOutput("timeout_period_hold", int'(period), 100);
        checkOutput("timeout_high_hold", int'(high_time), 50);
      end
    end
    measuring = 1'b0;

    $display("[TB] restart after timeout");
    applyStimulus(100, 50);
    checkOutput("timeout_sticky_in_arm", int'(timeout), 1);
    repeat (2) applyStimulus(100, 50);
    checkOutput("timeout_cleared", int'(timeout), 0);

    $display("[TB] disable mid-measurement");
    modelStart(100, 50);
    sig_in = 1'b1;
    repeat (50) @(negedge clk_in);
    sig_in = 1'b0;
    repeat (10) @(negedge clk_in);
    en = 1'b0;
    repeat (2) @(negedge clk_in);
    checkOutput("disable_locked", int'(locked), 0);
    checkOutput("disable_timeout", int'(timeout), 0);
    checkOutput("disable_period_hold", int'(period), lastP);
    checkOutput("disable_high_hold", int'(high_time), lastH);
    measuring = 1'b0;
    repeat (10) @(negedge clk_in);
    en = 1'b1;
    repeat (28) @(negedge clk_in);
    repeat (3) applyStimulus(100, 50);

    $display("[TB] reset mid-measurement with input high");
    modelStart(100, 50);
    sig_in = 1'b1;
    repeat (20) @(negedge clk_in);
    reset = 1'b1;
    @(negedge clk_in);
    checkAllZero("mid_reset");
    @(negedge clk_in);
    reset     = 1'b0;
    measuring = 1'b0;
    modelStart(100, 50);
    repeat (50) @(negedge clk_in);
    sig_in = 1'b0;
    repeat (50) @(negedge clk_in);
    repeat (2) applyStimulus(100, 50);

    modelStart(100, 50);
    sig_in = 1'b1;
    repeat (10) @(negedge clk_in);
    sig_in = 1'b0;
    repeat (10) @(negedge clk_in);
    checkOutput("queue_drained", expQueue.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
